// File: rtl/display_scan.sv
// display_scan: 8-digit multiplexed seven-segment driver with serial double-dabble BCD conversion.
// Define DISPLAY_ALARM_BLINK_EN to blink the digits and pulse the buzzer while Alarm is high.
module display_scan #(
    parameter int SCAN_DIV  = 10,
    parameter int BLINK_DIV = 2500,
    parameter int BUZZ_DIV  = 2
) (
    input  logic       Clock_5K,
    input  logic       Reset,
    input  logic [3:0] Hours,
    input  logic [5:0] Mins,
    input  logic [5:0] Secs,
    input  logic [9:0] MSecs,
    input  logic       AM_PM,
    input  logic       Alarm,
    input  logic       Control,
    output logic [6:0] Seg,
    output logic       Dp,
    output logic [7:0] Digit_En,
    output logic       Buzzer
);
    localparam int SCW = $clog2(SCAN_DIV);
    localparam logic [SCW-1:0] SC_MAX = SCW'(SCAN_DIV - 1);
    localparam logic [3:0] BLANK = 4'd10, GA = 4'd11, GP = 4'd12;

    if (SCAN_DIV < 6 || BLINK_DIV < 1 || BUZZ_DIV < 1) begin : g_bad_params
        $error("display_scan: SCAN_DIV must be >= 6, BLINK_DIV and BUZZ_DIV >= 1");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;
    state_t state;

    logic [SCW-1:0] sc;
    logic [2:0]  di, cur;
    logic        live, wrap, snap, done, off;
    logic [3:0]  h_s;
    logic [5:0]  m_s, s_s;
    logic [9:0]  ms_s, val, fv;
    logic        pm_s, ctl_s;
    logic [1:0]  fld;
    logic [3:0]  cnt, code;
    logic [11:0] bcd, adj;
    logic [11:0] pend [4];
    logic [11:0] disp [4];
    logic        dp_n;

    function automatic logic [3:0] dab(input logic [3:0] x);
        return x >= 4'd5 ? x + 4'd3 : x;
    endfunction

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'd0: return 7'b0111111;
            4'd1: return 7'b0000110;
            4'd2: return 7'b1011011;
            4'd3: return 7'b1001111;
            4'd4: return 7'b1100110;
            4'd5: return 7'b1101101;
            4'd6: return 7'b1111101;
            4'd7: return 7'b0000111;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1101111;
            GA:   return 7'b1110111;
            GP:   return 7'b1110011;
            default: return 7'b0000000;
        endcase
    endfunction

    assign wrap = sc == SC_MAX;
    assign snap = wrap && di == 3'd7;
    assign adj  = {dab(bcd[11:8]), dab(bcd[7:4]), dab(bcd[3:0])};
    assign fv   = fld == 2'd0 ? {6'd0, h_s} : fld == 2'd1 ? {4'd0, m_s} : fld == 2'd2 ? {4'd0, s_s} : ms_s;

    always_ff @(posedge Clock_5K) begin
        if (!Reset) begin
            sc    <= '0;
            di    <= '0;
            cur   <= '0;
            live  <= 1'b0;
            h_s   <= '0;
            m_s   <= '0;
            s_s   <= '0;
            ms_s  <= '0;
            pm_s  <= 1'b0;
            ctl_s <= 1'b0;
        end else begin
            sc <= wrap ? '0 : sc + 1'b1;
            if (wrap) begin
                di   <= di + 3'd1;
                cur  <= di;
                live <= 1'b1;
            end
            if (snap) begin
                h_s   <= Hours;
                m_s   <= Mins;
                s_s   <= Secs;
                ms_s  <= MSecs;
                pm_s  <= AM_PM;
                ctl_s <= Control;
            end
        end
    end

    always_ff @(posedge Clock_5K) begin
        if (!Reset) begin
            state <= IDLE;
            fld   <= '0;
            cnt   <= '0;
            val   <= '0;
            bcd   <= '0;
            done  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pend[i] <= '0;
                disp[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (done)
                for (int i = 0; i < 4; i++) disp[i] <= pend[i];
            case (state)
                IDLE: if (snap) begin
                    state <= LOAD;
                    fld   <= '0;
                end
                LOAD: begin
                    val   <= fv;
                    bcd   <= '0;
                    cnt   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    {bcd, val} <= {adj, val} << 1;
                    cnt        <= cnt + 4'd1;
                    state      <= cnt == 4'd9 ? STORE : SHIFT;
                end
                default: begin
                    pend[fld] <= bcd;
                    fld       <= fld + 2'd1;
                    done      <= fld == 2'd3;
                    state     <= fld == 2'd3 ? IDLE : LOAD;
                end
            endcase
        end
    end

    // Digit layout per slot; bank 0..3 holds Hours, Mins, Secs, MSecs as 3 BCD digits each
    always_comb begin
        code = BLANK;
        if (ctl_s)
            case (cur)
                3'd7: code = disp[0][7:4] == 4'd0 ? BLANK : disp[0][7:4];
                3'd6: code = disp[0][3:0];
                3'd5: code = disp[1][7:4];
                3'd4: code = disp[1][3:0];
                3'd3: code = disp[2][7:4];
                3'd2: code = disp[2][3:0];
                3'd1: code = pm_s ? GP : GA;
                default: code = BLANK;
            endcase
        else
            case (cur)
                3'd7: code = disp[0][3:0];
                3'd6: code = disp[1][7:4];
                3'd5: code = disp[1][3:0];
                3'd4: code = disp[2][7:4];
                3'd3: code = disp[2][3:0];
                3'd2: code = disp[3][11:8];
                3'd1: code = disp[3][7:4];
                default: code = disp[3][3:0];
            endcase
        dp_n = ctl_s ? (cur == 3'd6 || cur == 3'd4) : (cur == 3'd7 || cur == 3'd5 || cur == 3'd3);
    end

    always_ff @(posedge Clock_5K) begin
        if (!Reset) begin
            Seg      <= '0;
            Dp       <= 1'b0;
            Digit_En <= 8'hFF;
        end else begin
            Seg      <= live ? glyph(code) : '0;
            Dp       <= live && dp_n;
            Digit_En <= live && !off ? ~(8'd1 << cur) : 8'hFF;
        end
    end

`ifdef DISPLAY_ALARM_BLINK_EN
    localparam int BLW = $clog2(BLINK_DIV + 1);
    localparam int BZW = $clog2(BUZZ_DIV + 1);
    logic [BLW-1:0] bc;
    logic [BZW-1:0] bz;

    always_ff @(posedge Clock_5K) begin
        if (!Reset || !Alarm) begin
            bc     <= '0;
            bz     <= '0;
            off    <= 1'b0;
            Buzzer <= 1'b0;
        end else begin
            bc     <= bc == BLW'(BLINK_DIV - 1) ? '0 : bc + 1'b1;
            bz     <= bz == BZW'(BUZZ_DIV - 1) ? '0 : bz + 1'b1;
            off    <= bc == BLW'(BLINK_DIV - 1) ? ~off : off;
            Buzzer <= off ? 1'b0 : bz == BZW'(BUZZ_DIV - 1) ? ~Buzzer : Buzzer;
        end
    end
`else
    assign off = 1'b0;

    always_ff @(posedge Clock_5K) begin
        if (!Reset) Buzzer <= 1'b0;
        else Buzzer <= Alarm;
    end
`endif
endmodule
